// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared FSM encoding, error codes and default sync byte for the UART packet parser
package uart_pkt_pkg;
  typedef enum logic [2:0] {S_IDLE, S_OP, S_LEN, S_PAYLOAD, S_CSUM} state_t;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;
endpackage

// File: rtl/uart_pkt_parser_timeout.sv
// byte_timeout: inter-byte timeout counter for the packet parser
// clk50/rst_n: clock and async active-low reset; clr: restart on a received byte;
// en: count only while a packet is open; expire: count reached TIMEOUT_CYC-1
module byte_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk50,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] cnt;
  assign expire = en && cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (clr || !en) ? '0 : (expire ? cnt : cnt + 1'b1);
endmodule

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: frames SYNC,OP,LEN,payload,CSUM packets from a UART byte stream
// clk50/rst_n: clock and async active-low reset; rx_byte/rx_valid: received byte and strobe
// pkt_valid/pkt_op/pkt_len/pkt_payload: good-packet pulse and held packet fields
// err_valid/err_code/err_cnt: error pulse, held error code, saturating error count
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN     = 8,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic        clk50,
  input  logic        rst_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic        pkt_valid,
  output logic [7:0]  pkt_op,
  output logic [3:0]  pkt_len,
  output logic [63:0] pkt_payload,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [7:0]  err_cnt
);
  state_t state, nxt;
  logic [7:0] op_r, csum;
  logic [3:0] len_r, idx;
  logic [63:0] pay_r;
  logic good, err, tmo;
  logic [1:0] code;
  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk50 (clk50),
    .rst_n (rst_n),
    .clr   (rx_valid),
    .en    (state != S_IDLE),
    .expire(tmo)
  );
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;
  // a byte arriving on the expiry cycle takes precedence over the timeout
  always_comb begin
    nxt = state;
    good = 1'b0;
    err = 1'b0;
    code = ERR_LEN;
    if (rx_valid)
      case (state)
        S_IDLE: nxt = rx_byte == SYNC_BYTE ? S_OP : S_IDLE;
        S_OP: nxt = S_LEN;
        S_LEN: begin
          err = rx_byte > 8'(MAX_LEN);
          nxt = err ? S_IDLE : (rx_byte == 8'd0 ? S_CSUM : S_PAYLOAD);
        end
        S_PAYLOAD: nxt = idx == len_r - 4'd1 ? S_CSUM : S_PAYLOAD;
        S_CSUM: begin
          good = rx_byte == csum;
          err = !good;
          code = ERR_CSUM;
          nxt = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    else if (tmo) begin
      err = 1'b1;
      code = ERR_TMO;
      nxt = S_IDLE;
    end
  end
  // OP reseeds the running XOR, so folding in bytes seen in IDLE/CSUM is harmless
  always_ff @(posedge clk50 or negedge rst_n)
    if (!rst_n) begin
      op_r <= '0;
      csum <= '0;
      len_r <= '0;
      idx <= '0;
      pay_r <= '0;
      pkt_valid <= 1'b0;
      pkt_op <= '0;
      pkt_len <= '0;
      pkt_payload <= '0;
      err_valid <= 1'b0;
      err_code <= '0;
      err_cnt <= '0;
    end else begin
      pkt_valid <= good;
      err_valid <= err;
      if (err) begin
        err_code <= code;
        err_cnt <= err_cnt + {7'd0, err_cnt != 8'hFF};
      end
      if (good) begin
        pkt_op <= op_r;
        pkt_len <= len_r;
        pkt_payload <= pay_r;
      end
      if (rx_valid) begin
        csum <= state == S_OP ? rx_byte : csum ^ rx_byte;
        if (state == S_OP) op_r <= rx_byte;
        if (state == S_LEN) begin
          len_r <= rx_byte[3:0];
          idx <= '0;
          pay_r <= '0;
        end
        if (state == S_PAYLOAD) begin
          pay_r[{idx[2:0], 3'b000} +: 8] <= rx_byte;
          idx <= idx + 4'd1;
        end
      end
    end
endmodule

// File: tb/tb_uart_pkt_parser.sv
// tb_uart_pkt_parser: directed stimulus checked every cycle against a queue-based packet model
module tb_uart_pkt_parser;
  localparam int TMO = 200;
  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic rx_valid = 1'b0;
  logic pkt_valid, err_valid;
  logic [7:0] pkt_op, err_cnt;
  logic [3:0] pkt_len;
  logic [63:0] pkt_payload;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  int pv_cnt = 0;
  int pv_base;
  logic m_pv = 1'b0, m_ev = 1'b0;
  logic [7:0] m_op = '0, m_cnt = '0;
  logic [3:0] m_len = '0;
  logic [63:0] m_pay = '0;
  logic [1:0] m_code = '0;
  logic [7:0] q[$];
  int gap = 0;
  uart_pkt_parser #(.TIMEOUT_CYC(TMO)) dut (
    .clk50(clk50), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .pkt_valid(pkt_valid), .pkt_op(pkt_op), .pkt_len(pkt_len), .pkt_payload(pkt_payload),
    .err_valid(err_valid), .err_code(err_code), .err_cnt(err_cnt)
  );
  always #5 clk50 = ~clk50;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_err(input logic [1:0] c);
    m_ev = 1'b1;
    m_code = c;
    if (m_cnt != 8'hFF) m_cnt++;
    q.delete();
  endtask
  // packet model: buffer bytes from SYNC onward and judge the packet once LEN+4 bytes are held
  initial forever begin
    @(posedge clk50 or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      gap = 0;
      {m_pv, m_ev, m_op, m_len, m_pay, m_code, m_cnt} = '0;
    end else begin
      m_pv = 1'b0;
      m_ev = 1'b0;
      if (rx_valid) begin
        gap = 0;
        if (q.size() != 0 || rx_byte == 8'hA5) q.push_back(rx_byte);
        if (q.size() == 3 && q[2] > 8) model_err(2'd1);
        else if (q.size() >= 4 && q.size() == int'(q[2]) + 4) begin
          logic [7:0] x;
          x = '0;
          for (int i = 1; i < q.size() - 1; i++) x ^= q[i];
          if (x == q[q.size() - 1]) begin
            m_pv = 1'b1;
            m_op = q[1];
            m_len = q[2][3:0];
            m_pay = '0;
            for (int k = 0; k < int'(q[2]); k++) m_pay[8*k +: 8] = q[3 + k];
            q.delete();
          end else model_err(2'd2);
        end
      end else if (q.size() != 0) begin
        gap++;
        if (gap == TMO) model_err(2'd3);
      end
    end
  end
  initial forever begin
    @(negedge clk50);
    pv_cnt += int'(pkt_valid);
    chk("pkt_valid", pkt_valid, m_pv);
    chk("err_valid", err_valid, m_ev);
    chk("pkt_op", pkt_op, m_op);
    chk("pkt_len", pkt_len, m_len);
    chk("pkt_payload", pkt_payload, m_pay);
    chk("err_code", err_code, m_code);
    chk("err_cnt", err_cnt, m_cnt);
    chk("pv_ev_excl", pkt_valid & err_valid, 0);
  end
  task automatic send(input logic [7:0] b);
    @(negedge clk50);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk50);
    rx_valid = 1'b0;
  endtask
  task automatic send_seq(input logic [95:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[8*i +: 8]);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk50);
  endtask
  initial begin
    idle(3);
    chk("rst_pkt_op", pkt_op, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle(2);
    send_seq(96'h00_FF, 2);
    send_seq(96'hA5_01_02_11_22_30, 6);
    chk("a_pv", pkt_valid, 1);
    chk("a_op", pkt_op, 8'h01);
    chk("a_len", pkt_len, 2);
    chk("a_pay", pkt_payload, 64'h2211);
    chk("a_cnt", err_cnt, 0);
    send_seq(96'hA5_01_02_11_22_31, 6);
    chk("c_ev", err_valid, 1);
    chk("c_code", err_code, 2);
    chk("c_pay", pkt_payload, 64'h2211);
    chk("c_cnt", err_cnt, 1);
    send_seq(96'hA5_07_00_07, 4);
    chk("b_pv", pkt_valid, 1);
    chk("b_len", pkt_len, 0);
    chk("b_pay", pkt_payload, 0);
    send_seq(96'hA5_01_09, 3);
    chk("d_ev", err_valid, 1);
    chk("d_code", err_code, 1);
    send_seq(96'hA5_03_08_11_22_33_44_55_66_77_88_83, 12);
    chk("max_pv", pkt_valid, 1);
    chk("max_pay", pkt_payload, 64'h8877665544332211);
    send_seq(96'hA5_A5_01_A5_01, 5);
    chk("sync_op", pkt_op, 8'hA5);
    chk("sync_pay", pkt_payload, 64'hA5);
    send_seq(96'hA5_01, 2);
    idle(TMO - 1);
    chk("tmo_early", err_valid, 0);
    idle(1);
    chk("tmo_ev", err_valid, 1);
    chk("tmo_code", err_code, 3);
    send_seq(96'hA5_01, 2);
    idle(TMO - 2);
    send(8'h00);
    chk("edge_ev", err_valid, 0);
    chk("edge_cnt", err_cnt, 3);
    idle(TMO);
    chk("edge_tmo", err_code, 3);
    chk("edge_cnt2", err_cnt, 4);
    send_seq(96'hA5_01_03_11, 4);
    #2 rst_n = 1'b0;
    idle(2);
    chk("mid_rst_op", pkt_op, 0);
    rst_n = 1'b1;
    pv_base = pv_cnt;
    send_seq(96'h22_33_A5_01_02_11_22_30, 8);
    idle(2);
    chk("rst_pulses", pv_cnt - pv_base, 1);
    chk("rst_cnt", err_cnt, 0);
    for (int i = 0; i < 300; i++) send_seq(96'hA5_01_00_00, 4);
    chk("sat_cnt", err_cnt, 8'hFF);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
